// File: rtl/led_blink_pkg.sv
// Shared types and constants for the LED status-code blinker.
// Optional build macro LED_BLINK_ONESHOT_EN is consumed in led_blink_ctrl.sv.
package led_blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [27:0] DEF_FREQ      = 28'd25_000_000;
    localparam logic [7:0]  DEF_ON_TICKS  = 8'd16;
    localparam logic [7:0]  DEF_OFF_TICKS = 8'd16;
    localparam logic [7:0]  DEF_GAP_TICKS = 8'd64;

    // The tick period is FREQ >> TICK_SHIFT clock cycles (about 15.6 ms).
    localparam int TICK_SHIFT = 6;

    // A phase ends on the tick that completes its lim-th tick.
    function automatic logic phase_done(input logic       tick,
                                        input logic [7:0] ph,
                                        input logic [7:0] lim);
        return tick && (ph == (lim - 8'd1));
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: one-cycle pulse every FREQ/64 clock cycles.
// The count restarts whenever clr is high.
module led_tick_gen
    import led_blink_pkg::*;
#(
    parameter logic [27:0] FREQ = DEF_FREQ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [21:0] TICK_MAX = FREQ[27:TICK_SHIFT];

    logic [21:0] tick_cnt_r;

    assign tick = (tick_cnt_r == (TICK_MAX - 22'd1));

    // Tick counter, wraps on tick and restarts on clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_r <= 22'd0;
        end else if (clr || tick) begin
            tick_cnt_r <= 22'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 22'd1;
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED status-code driver: N blinks then a dark gap, repeated per round.
// Define LED_BLINK_ONESHOT_EN to play each loaded code for a single round.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter logic [27:0] FREQ      = DEF_FREQ,
    parameter logic [7:0]  ON_TICKS  = DEF_ON_TICKS,
    parameter logic [7:0]  OFF_TICKS = DEF_OFF_TICKS,
    parameter logic [7:0]  GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code_in,
    input  logic       code_vld,
    output logic       led_out,
    output logic       busy
);

    state_t     state_r, state_nxt_s;
    logic [3:0] cur_code_r, cur_code_nxt_s;
    logic [3:0] blk_cnt_r, blk_cnt_nxt_s;
    logic [3:0] pend_code_r, pend_code_nxt_s;
    logic       pend_vld_r, pend_vld_nxt_s;
    logic [3:0] new_code_s;
    logic [7:0] ph_cnt_r;
    logic       tick_s;
    logic       clr_s;

    // Tick phase restarts on every state entry and is parked while idle.
    assign clr_s = (state_r == IDLE) || (state_nxt_s != state_r);

    led_tick_gen #(.FREQ(FREQ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Same-cycle load at round end takes priority over an older pending code.
    assign new_code_s = code_vld ? code_in : pend_code_r;

    // Next-state and round bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        cur_code_nxt_s  = cur_code_r;
        blk_cnt_nxt_s   = blk_cnt_r;
        pend_code_nxt_s = pend_code_r;
        pend_vld_nxt_s  = pend_vld_r;

        if ((state_r != IDLE) && code_vld) begin
            pend_code_nxt_s = code_in;
            pend_vld_nxt_s  = 1'b1;
        end else begin
            pend_vld_nxt_s  = pend_vld_r;
        end

        case (state_r)
            IDLE: begin
                if (code_vld && (code_in != 4'd0)) begin
                    cur_code_nxt_s = code_in;
                    blk_cnt_nxt_s  = 4'd0;
                    state_nxt_s    = ON;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            ON: begin
                if (phase_done(tick_s, ph_cnt_r, ON_TICKS)) begin
                    blk_cnt_nxt_s = blk_cnt_r + 4'd1;
                    state_nxt_s   = OFF;
                end else begin
                    state_nxt_s   = ON;
                end
            end
            OFF: begin
                if (phase_done(tick_s, ph_cnt_r, OFF_TICKS)) begin
                    state_nxt_s = (blk_cnt_r < cur_code_r) ? ON : GAP;
                end else begin
                    state_nxt_s = OFF;
                end
            end
            GAP: begin
                if (phase_done(tick_s, ph_cnt_r, GAP_TICKS)) begin
                    pend_vld_nxt_s = 1'b0;
                    if (code_vld || pend_vld_r) begin
                        cur_code_nxt_s = new_code_s;
                        blk_cnt_nxt_s  = 4'd0;
                        state_nxt_s    = (new_code_s == 4'd0) ? IDLE : ON;
                    end else begin
`ifdef LED_BLINK_ONESHOT_EN
                        state_nxt_s    = IDLE;
`else
                        blk_cnt_nxt_s  = 4'd0;
                        state_nxt_s    = ON;
`endif
                    end
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, round registers and registered LED/busy outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_code_r  <= 4'd0;
            blk_cnt_r   <= 4'd0;
            pend_code_r <= 4'd0;
            pend_vld_r  <= 1'b0;
            led_out     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_code_r  <= cur_code_nxt_s;
            blk_cnt_r   <= blk_cnt_nxt_s;
            pend_code_r <= pend_code_nxt_s;
            pend_vld_r  <= pend_vld_nxt_s;
            led_out     <= (state_nxt_s == ON);
            busy        <= (state_nxt_s != IDLE);
        end
    end

    // Ticks elapsed within the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_cnt_r <= 8'd0;
        end else if (state_nxt_s != state_r) begin
            ph_cnt_r <= 8'd0;
        end else if (tick_s && (state_r != IDLE)) begin
            ph_cnt_r <= ph_cnt_r + 8'd1;
        end else begin
            ph_cnt_r <= ph_cnt_r;
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: a round-position model predicts led/busy
// for every cycle; a negedge monitor compares. Honours LED_BLINK_ONESHOT_EN.
module tb_led_blink_ctrl;

    localparam int TM     = 10;             // 640 >> 6
    localparam int ON_CYC = 2 * TM;
    localparam int PULSE  = (2 + 2) * TM;
    localparam int GAP_CY = 4 * TM;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_vld = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       led_out;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [1:0] exp_q[$];

    // Model: position inside the current round, plus pending code.
    bit m_act = 1'b0;
    int m_n   = 0;
    int m_pos = 0;
    bit m_pv  = 1'b0;
    int m_pc  = 0;

    led_blink_ctrl #(
        .FREQ      (28'd640),
        .ON_TICKS  (8'd2),
        .OFF_TICKS (8'd2),
        .GAP_TICKS (8'd4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .code_in  (code_in),
        .code_vld (code_vld),
        .led_out  (led_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int round_len(input int n);
        return n * PULSE + GAP_CY;
    endfunction

    task automatic model_edge(input bit r, input bit v, input int c);
        int  nc;
        bit  have;
        if (!r) begin
            m_act = 1'b0;
            m_pv  = 1'b0;
        end else if (!m_act) begin
            if (v && (c != 0)) begin
                m_act = 1'b1;
                m_n   = c;
                m_pos = 0;
            end
        end else if (m_pos + 1 == round_len(m_n)) begin
            have = v || m_pv;
            nc   = v ? c : m_pc;
            m_pv = 1'b0;
            if (!have) begin
`ifdef LED_BLINK_ONESHOT_EN
                nc = 0;
`else
                nc = m_n;
`endif
            end
            if (nc == 0) begin
                m_act = 1'b0;
            end else begin
                m_n   = nc;
                m_pos = 0;
            end
        end else begin
            m_pos++;
            if (v) begin
                m_pv = 1'b1;
                m_pc = c;
            end
        end
    endtask

    function automatic bit model_led();
        return m_act && (m_pos < m_n * PULSE) && ((m_pos % PULSE) < ON_CYC);
    endfunction

    task automatic step(input bit r, input bit v, input int c);
        @(negedge clk);
        rst_n    = r;
        code_vld = v;
        code_in  = c[3:0];
        @(posedge clk);
        cyc++;
        model_edge(r, v, c);
        exp_q.push_back({model_led(), m_act});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    // Monitor: one comparison per clock against the scoreboard.
    always @(negedge clk) begin
        logic [1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({led_out, busy} !== e) begin
                fails++;
                $display("FAIL cyc%0d led_busy: got led=%b busy=%b, expected led=%b busy=%b",
                         cyc, led_out, busy, e[1], e[0]);
            end
        end
    end

    initial begin
        int guard;
        int r;

        // Reset, then code 0 in IDLE is ignored.
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        idle(3);
        step(1'b1, 1'b1, 0);
        idle(5);

        // Code 3: two full rounds.
        step(1'b1, 1'b1, 3);
        idle(2 * round_len(3));

        // Code 2 mid-round, then two loads within one round (last wins).
        idle(37);
        step(1'b1, 1'b1, 2);
        idle(round_len(3) + round_len(2));
        step(1'b1, 1'b1, 4);
        idle(11);
        step(1'b1, 1'b1, 1);
        idle(2 * round_len(4));

        // Load code 5 exactly on the GAP-expiry cycle.
        guard = 0;
        while (!(m_act && (m_pos + 1 == round_len(m_n))) && guard < 2000) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        tests++;
        if (guard >= 2000) begin
            fails++;
            $display("FAIL gap_expiry_wait: waited %0d cycles, limit 2000", guard);
        end
        step(1'b1, 1'b1, 5);
        idle(round_len(5) + 20);

        // Code 0 while running: finish round then IDLE.
        step(1'b1, 1'b1, 0);
        idle(round_len(5) + 30);

        // Code 15 one full round (no wrap of the blink count).
        step(1'b1, 1'b1, 15);
        idle(round_len(15) + 15);

        // One-cycle reset during ON discards pending code.
        step(1'b1, 1'b1, 7);
        guard = 0;
        while (!model_led() && guard < 2000) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        idle(5);
        step(1'b0, 1'b0, 0);
        idle(200);

        // Randomised loads and occasional resets.
        for (int k = 0; k < 30; k++) begin
            idle($urandom_range(1, 150));
            r = $urandom_range(0, 19);
            if (r == 0) step(1'b0, 1'b0, 0);
            else        step(1'b1, 1'b1, $urandom_range(0, 15));
        end
        idle(400);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

LED status-code driver: the human-facing output counterpart of the key input path. It accepts a 4-bit status code from control logic, such as the DDR3 test sequencer. It then drives one LED as a repeating blink pattern: N on/off pulses, then a long dark gap. All timing derives from the FREQ parameter, so the visible pattern is frequency independent.

## Interface
- FREQ, 28'd25_000_000: input clock frequency in Hz.
- ON_TICKS, 8'd16: LED on time per blink, in ticks.
- OFF_TICKS, 8'd16: LED off time between blinks, in ticks.
- GAP_TICKS, 8'd64: dark gap after the last blink of a round, in ticks.
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- code_in  input  4  status code: number of blinks per round; 0 means LED off.
- code_vld  input  1  one-cycle load strobe for code_in.
- led_out  output  1  LED drive, high = lit. Registered.
- busy  output  1  high whenever state != IDLE. Registered.

## Operation
- Tick: TICK_MAX = FREQ[27:6] (FREQ/64, truncated; about 15.6 ms), 22-bit counter.
  - The counter is held at 0 in IDLE and restarts from 0 on every state entry.
  - tick asserts when tick_cnt == TICK_MAX-1.
- Phase counter ph_cnt (8 bit) counts ticks within the current state and clears on every state change.
- Blink counter blk_cnt (4 bit) counts completed blinks in the current round.
- States:
  - IDLE: led 0. If code_vld and code_in != 0: cur_code <= code_in, blk_cnt <= 0, go to ON.
  - ON: led 1. After ON_TICKS ticks go to OFF, blk_cnt <= blk_cnt+1.
  - OFF: led 0. After OFF_TICKS ticks: if blk_cnt < cur_code go to ON, else go to GAP.
  - GAP: led 0. After GAP_TICKS ticks, end of round:
    - If pend_vld: cur_code <= pend_code and pend_vld <= 0. If that code is 0, go to IDLE; otherwise blk_cnt <= 0 and go to ON.
    - Otherwise repeat the round with cur_code (see Configuration).
- Load while not IDLE: pend_code <= code_in and pend_vld <= 1. The current round always completes unaltered.
- Several loads within one round: the last one wins.
- code_vld on the same cycle GAP expires: the new code_in is used directly; it is not deferred a further round.
- Code 0 loaded in IDLE: ignored, state stays IDLE.
- Code 15: 15 blinks per round; blk_cnt never wraps.

## Timing
- Reset values: led_out 0, busy 0, state IDLE, all counters 0, pend_vld 0.
- Reset mid-sequence: led_out is 0 from the first edge that samples rst_n low. Any pending code is discarded.
- Load latency: with code_vld sampled at edge k from IDLE, led_out and busy are both 1 after edge k.
- Cycle counts per phase:
  - ON lasts exactly ON_TICKS×TICK_MAX cycles.
  - OFF lasts OFF_TICKS×TICK_MAX cycles.
  - GAP lasts GAP_TICKS×TICK_MAX cycles.
- Round length for code N: N×(ON_TICKS+OFF_TICKS)×TICK_MAX + GAP_TICKS×TICK_MAX.
- busy falls on the same edge as the GAP→IDLE transition.

## Configuration
- LED_BLINK_ONESHOT_EN defined: at GAP end with no pending code, go to IDLE. Each load plays exactly one round.
- LED_BLINK_ONESHOT_EN undefined (default): at GAP end with no pending code, repeat cur_code indefinitely until code 0 is loaded or reset is applied.

## Structure
- Package led_blink_pkg holds:
  - the state encoding (IDLE, ON, OFF, GAP; 2 bits);
  - default tick constants;
  - the TICK_SHIFT = 6 constant.
- Sub-module led_tick_gen:
  - Parameterised by FREQ; inputs clk, rst_n, clr; output tick.
  - Contains the 22-bit tick counter.

## Test plan
Bench uses FREQ=640 (TICK_MAX=10), ON/OFF_TICKS=2, GAP_TICKS=4.
- Load code 3 from IDLE → led_out high on the next cycle. Sequence is 3 pulses of 20 cycles high / 20 low, then 40 dark; round length 160 cycles, then repeats.
- Load code 2 mid-round of code 3 → current round completes with 3 pulses; the next round has 2 pulses.
- Load code 0 while running → current round finishes, then IDLE; busy drops at GAP end; led stays 0.
- code_vld with code 5 on the GAP-expiry cycle → the immediately following round has 5 pulses.
- Assert rst_n low for 1 cycle during ON → led_out 0 and busy 0 next cycle; no pulses until a new load.
- With LED_BLINK_ONESHOT_EN, load code 1 → one 20-cycle pulse, 20 off, 40 gap, then IDLE (busy 0) after 80 cycles.
